// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped, write-back, write-allocate data cache.
// 8 lines x 4 bytes; address = {tag[7:5], index[4:2], offset[1:0]}.
// Blocks move to/from memory as 4 sequential byte beats separated by BEAT_GAP idle cycles.
// Optional build macro DCACHE_STATS_EN adds saturating hit_count / miss_count outputs.
module dcache_controller #(
  parameter int unsigned BEAT_GAP = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        read,
  input  logic        write,
  input  logic [7:0]  address,
  input  logic [7:0]  writedata,
  output logic [7:0]  readdata,
  output logic        busywait,
  output logic        mem_read,
  output logic        mem_write,
  output logic [7:0]  mem_address,
  output logic [7:0]  mem_writedata,
  input  logic [7:0]  mem_readdata,
  input  logic        mem_busywait
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);

  typedef enum logic [1:0] {StIdle, StWriteback, StFetch, StUpdate} state_e;

  state_e     state_q, state_d;
  logic [1:0] beat_q, beat_d;
  logic [7:0] gap_q, gap_d;
  logic       strobe_q, strobe_d;
  logic [7:0] valid_q, dirty_q;
  logic [2:0] tag_q [8];
  logic [7:0] data_q [32];

  logic [2:0] tag, index;
  logic [1:0] offset;
  logic       req, hit, idle_hit, strobe_on, beat_done, last_beat;

  assign tag    = address[7:5];
  assign index  = address[4:2];
  assign offset = address[1:0];

  // read and write together is treated as no request at all
  assign req       = read ^ write;
  assign hit       = valid_q[index] && (tag_q[index] == tag);
  assign idle_hit  = (state_q == StIdle) && hit;
  assign strobe_on = ((state_q == StWriteback) || (state_q == StFetch)) && (gap_q == 8'd0);
  // a beat needs the strobe to have been seen by memory for at least one prior cycle
  assign beat_done = strobe_on && strobe_q && !mem_busywait;
  assign last_beat = (beat_q == 2'd3);

  // Next-state logic: miss dispatch, beat sequencing and inter-beat gaps
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    gap_d    = (gap_q != 8'd0) ? gap_q - 8'd1 : 8'd0;
    strobe_d = strobe_on && !beat_done;
    unique case (state_q)
      StIdle: begin
        if (req && !hit) begin
          beat_d  = 2'd0;
          state_d = (valid_q[index] && dirty_q[index]) ? StWriteback : StFetch;
        end
      end
      StWriteback, StFetch: begin
        if (beat_done) begin
          beat_d = beat_q + 2'd1;
          gap_d  = 8'(BEAT_GAP);
          if (last_beat) begin
            state_d = (state_q == StWriteback) ? StFetch : StUpdate;
          end
        end
      end
      StUpdate: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Control state and line metadata
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      beat_q   <= 2'd0;
      gap_q    <= 8'd0;
      strobe_q <= 1'b0;
      valid_q  <= 8'd0;
      dirty_q  <= 8'd0;
      for (int i = 0; i < 8; i++) begin
        tag_q[i] <= 3'd0;
      end
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      gap_q    <= gap_d;
      strobe_q <= strobe_d;
      // line is invalid while being refilled so an aborted fill never looks valid
      if ((state_q == StIdle) && req && !hit) begin
        valid_q[index] <= 1'b0;
      end
      if (idle_hit && write && !read) begin
        dirty_q[index] <= 1'b1;
      end
      if ((state_q == StWriteback) && beat_done && last_beat) begin
        dirty_q[index] <= 1'b0;
      end
      if (state_q == StUpdate) begin
        valid_q[index] <= 1'b1;
        tag_q[index]   <= tag;
      end
    end
  end

  // Data array: CPU write hits and fill beats
  always_ff @(posedge clock) begin
    if (idle_hit && write && !read) begin
      data_q[{index, offset}] <= writedata;
    end
    if ((state_q == StFetch) && beat_done) begin
      data_q[{index, beat_q}] <= mem_readdata;
    end
  end

  // Outputs; forced to zero while reset is asserted
  always_comb begin
    readdata      = 8'd0;
    busywait      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = 8'd0;
    mem_writedata = 8'd0;
    if (!reset) begin
      busywait = req && !idle_hit;
      if (read && !write && idle_hit) begin
        readdata = data_q[{index, offset}];
      end
      if (strobe_on) begin
        if (state_q == StWriteback) begin
          mem_write     = 1'b1;
          mem_address   = {tag_q[index], index, beat_q};
          mem_writedata = data_q[{index, beat_q}];
        end else begin
          mem_read    = 1'b1;
          mem_address = {tag, index, beat_q};
        end
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic fill_done_q;

  // Count each request once at resolution; the hit right after a fill belongs to its miss
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fill_done_q <= 1'b0;
      hit_count   <= 16'd0;
      miss_count  <= 16'd0;
    end else begin
      fill_done_q <= (state_q == StUpdate);
      if ((state_q == StIdle) && req) begin
        if (!hit) begin
          if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
        end else if (!fill_done_q) begin
          if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: directed + randomized bench against a flat architectural memory model.
module tb_dcache_controller;

  localparam int BEAT_GAP = 1;
  localparam int LIMIT    = 2000;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       read = 1'b0, write = 1'b0;
  logic [7:0] address = 8'd0, writedata = 8'd0;
  logic [7:0] readdata, mem_address, mem_writedata, mem_readdata;
  logic       busywait, mem_read, mem_write, mem_busywait;
`ifdef DCACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  dcache_controller #(.BEAT_GAP(BEAT_GAP)) dut (
    .clock         (clock),
    .reset         (reset),
    .read          (read),
    .write         (write),
    .address       (address),
    .writedata     (writedata),
    .readdata      (readdata),
    .busywait      (busywait),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count     (hit_count),
    .miss_count    (miss_count)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- memory model ----------------
  logic [7:0]  tb_mem  [256];
  logic [7:0]  pre_mem [256];
  logic        load_req = 1'b0;
  logic        held = 1'b0;
  int          wait_cnt = 0;
  int          stall = 0;
  int          min_stall = 0;
  int          max_stall = 0;
  int          strobe_cycles = 0;
  int          beats = 0;
  logic [16:0] exp_q [$];   // {is_write, addr, wdata}

  assign mem_readdata = tb_mem[mem_address];
  assign mem_busywait = (mem_read || mem_write) && (wait_cnt < stall);

  // Memory: stalls 'stall' cycles per access, checks each completed beat against expectations
  always @(posedge clock) begin
    logic [16:0] e;
    if (load_req) begin
      for (int i = 0; i < 256; i++) tb_mem[i] <= pre_mem[i];
    end
    if (reset) begin
      held     <= 1'b0;
      wait_cnt <= 0;
      stall    <= min_stall;
    end else if (mem_read || mem_write) begin
      strobe_cycles <= strobe_cycles + 1;
      if (held && !mem_busywait) begin
        check("beat_pending", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("beat_kind", int'(mem_write), int'(e[16]));
          check("beat_addr", int'(mem_address), int'(e[15:8]));
          if (mem_write) check("beat_wdata", int'(mem_writedata), int'(e[7:0]));
        end
        if (mem_write) tb_mem[mem_address] <= mem_writedata;
        held     <= 1'b0;
        wait_cnt <= 0;
        beats    <= beats + 1;
      end else begin
        held     <= 1'b1;
        wait_cnt <= wait_cnt + 1;
      end
    end else begin
      held     <= 1'b0;
      wait_cnt <= 0;
      stall    <= int'($urandom_range(max_stall, min_stall));
    end
  end

  // Strobe monitor: exclusivity, stability within a beat, idle gap before each beat
  logic       prev_strobe = 1'b0;
  logic       prev_kind = 1'b0;
  logic [7:0] prev_addr = 8'd0, prev_wdata = 8'd0;
  int         low_run = 100;

  always @(negedge clock) begin
    if (reset) begin
      prev_strobe <= 1'b0;
      low_run     <= 100;
    end else begin
      if (mem_read || mem_write) begin
        check("strobe_overlap", int'(mem_read && mem_write), 0);
        if (prev_strobe) begin
          check("strobe_addr_stable", int'(mem_address), int'(prev_addr));
          check("strobe_kind_stable", int'(mem_write), int'(prev_kind));
          check("strobe_wdata_stable", int'(mem_writedata), int'(prev_wdata));
        end else begin
          check("beat_gap", int'(low_run >= BEAT_GAP), 1);
        end
        low_run <= 0;
      end else begin
        low_run <= low_run + 1;
      end
      prev_strobe <= mem_read || mem_write;
      prev_kind   <= mem_write;
      prev_addr   <= mem_address;
      prev_wdata  <= mem_writedata;
    end
  end

  // ---------------- cache / architectural model ----------------
  logic [7:0] cpu_view [256];
  logic       m_valid [8];
  logic       m_dirty [8];
  logic [2:0] m_tag   [8];
  int         m_hits = 0, m_misses = 0;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = 3'd0;
    end
    // dirty lines are lost on reset: the architectural view falls back to memory
    for (int i = 0; i < 256; i++) cpu_view[i] = tb_mem[i];
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic do_req(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] wd,
                        output int lat, output logic [7:0] rdata);
    logic [2:0] tg, idx;
    logic       rq, hit;
    int         sc0;
    tg  = a[7:5];
    idx = a[4:2];
    rq  = rd ^ wr;
    hit = m_valid[idx] && (m_tag[idx] == tg);
    if (rq) begin
      if (hit) begin
        m_hits++;
      end else begin
        m_misses++;
        if (m_valid[idx] && m_dirty[idx]) begin
          for (int b = 0; b < 4; b++)
            exp_q.push_back({1'b1, m_tag[idx], idx, 2'(b), cpu_view[{m_tag[idx], idx, 2'(b)}]});
        end
        for (int b = 0; b < 4; b++) exp_q.push_back({1'b0, tg, idx, 2'(b), 8'h00});
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tg;
        m_dirty[idx] = 1'b0;
      end
      if (wr) begin
        cpu_view[a]  = wd;
        m_dirty[idx] = 1'b1;
      end
    end
    @(posedge clock);
    #1;
    sc0       = strobe_cycles;
    read      = rd;
    write     = wr;
    address   = a;
    writedata = wd;
    @(negedge clock);
    check("busywait_first", int'(busywait), int'(rq && !hit));
    lat = 0;
    while (busywait && lat < LIMIT) begin
      lat++;
      @(negedge clock);
    end
    check("busywait_timeout", int'(lat < LIMIT), 1);
    rdata = readdata;
    if (rd && !wr) check("readdata", int'(readdata), int'(cpu_view[a]));
    @(posedge clock);
    #1;
    read  = 1'b0;
    write = 1'b0;
    check("beats_outstanding", exp_q.size(), 0);
    if (!(rq && !hit)) check("no_mem_traffic", strobe_cycles - sc0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int         lat, n, b0;
    logic [7:0] rdat, a, last_a;
    int         op;

    for (int i = 0; i < 256; i++) pre_mem[i] = 8'($urandom_range(0, 255));
    pre_mem[8'h04] = 8'h11; pre_mem[8'h05] = 8'h22; pre_mem[8'h06] = 8'h33; pre_mem[8'h07] = 8'h44;
    pre_mem[8'h24] = 8'h55; pre_mem[8'h25] = 8'h66; pre_mem[8'h26] = 8'h77; pre_mem[8'h27] = 8'h88;
    load_req = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1 load_req = 1'b0;
    @(negedge clock);
    check("rst_readdata", int'(readdata), 0);
    check("rst_busywait", int'(busywait), 0);
    check("rst_mem_read", int'(mem_read), 0);
    check("rst_mem_write", int'(mem_write), 0);
    check("rst_mem_address", int'(mem_address), 0);
    check("rst_mem_writedata", int'(mem_writedata), 0);
    @(posedge clock);
    #1 reset = 1'b0;
    model_reset();

    // cold read miss, then hits, write hit, dirty eviction
    do_req(1'b1, 1'b0, 8'h05, 8'h00, lat, rdat);
    check("lit_miss_latency", lat, 10 + 3 * BEAT_GAP);
    check("lit_read_05", int'(rdat), 8'h22);
    do_req(1'b1, 1'b0, 8'h06, 8'h00, lat, rdat);
    check("lit_hit_latency", lat, 0);
    check("lit_read_06", int'(rdat), 8'h33);
    do_req(1'b0, 1'b1, 8'h05, 8'hAB, lat, rdat);
    check("lit_write_hit_latency", lat, 0);
    do_req(1'b1, 1'b0, 8'h25, 8'h00, lat, rdat);
    check("lit_wb_fetch_latency", lat, 18 + 7 * BEAT_GAP);
    check("lit_read_25", int'(rdat), 8'h66);
    check("lit_mem_05", int'(tb_mem[8'h05]), 8'hAB);
    check("lit_mem_04", int'(tb_mem[8'h04]), 8'h11);
`ifdef DCACHE_STATS_EN
    check("lit_hit_count", int'(hit_count), 2);
    check("lit_miss_count", int'(miss_count), 2);
`endif

    // memory stalls 3 cycles on every beat
    min_stall = 3;
    max_stall = 3;
    do_req(1'b1, 1'b0, 8'h4C, 8'h00, lat, rdat);
    check("lit_stall_latency", lat, 18 + 3 * BEAT_GAP);
    min_stall = 0;
    max_stall = 3;

    // reset in the middle of the third fetch beat
    for (int b = 0; b < 4; b++) exp_q.push_back({1'b0, 3'd4, 3'd2, 2'(b), 8'h00});
    b0 = beats;
    @(posedge clock);
    #1;
    read    = 1'b1;
    address = 8'h88;
    n = 0;
    while (!((beats - b0) >= 2 && mem_read) && n < LIMIT) begin
      @(negedge clock);
      n++;
    end
    check("reach_beat2", int'(n < LIMIT), 1);
    #1 reset = 1'b1;
    #1;
    check("arst_readdata", int'(readdata), 0);
    check("arst_busywait", int'(busywait), 0);
    check("arst_mem_read", int'(mem_read), 0);
    check("arst_mem_write", int'(mem_write), 0);
    check("arst_mem_address", int'(mem_address), 0);
    check("arst_mem_writedata", int'(mem_writedata), 0);
    @(posedge clock);
    #1 read = 1'b0;
    @(posedge clock);
    #1 reset = 1'b0;
    exp_q.delete();
    model_reset();
    b0 = beats;
    do_req(1'b1, 1'b0, 8'h88, 8'h00, lat, rdat);
    check("lit_refetch_beats", beats - b0, 4);

    // randomized traffic
    last_a = 8'h00;
    for (int t = 0; t < 300; t++) begin
      repeat ($urandom_range(0, 2)) @(posedge clock);
      op = int'($urandom_range(0, 19));
      if ($urandom_range(0, 9) < 4) a = {last_a[7:2], 2'($urandom_range(0, 3))};
      else a = {3'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      last_a = a;
      do_req(op < 9 || op >= 18, op >= 9, a, 8'($urandom_range(0, 255)), lat, rdat);
    end

    // every byte not held dirty in the cache must be current in memory
    for (int i = 0; i < 256; i++) begin
      a = 8'(i);
      if (!(m_valid[a[4:2]] && m_dirty[a[4:2]] && m_tag[a[4:2]] == a[7:5]))
        check("mem_coherent", int'(tb_mem[i]), int'(cpu_view[i]));
    end
`ifdef DCACHE_STATS_EN
    check("stats_hits", int'(hit_count), m_hits);
    check("stats_misses", int'(miss_count), m_misses);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate data cache between the CPU load/store port and the 256x8 data memory.
- The CPU side presents the same read/write/address/writedata/readdata/busywait handshake as the data memory.
- The memory side is the initiator of that handshake: blocks are moved as 4 sequential byte accesses.
- 8 lines of 4 bytes; address split is tag[7:5], index[4:2], offset[1:0].

Parameters:
- BEAT_GAP, 1: idle cycles with both memory strobes low between consecutive memory accesses (minimum 1).

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- read  input  1  CPU load request
- write  input  1  CPU store request
- address  input  8  CPU byte address
- writedata  input  8  CPU store data
- readdata  output  8  CPU load data
- busywait  output  1  CPU stall; high while a request cannot complete this cycle
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- mem_address  output  8  memory byte address
- mem_writedata  output  8  memory write data
- mem_readdata  input  8  memory read data
- mem_busywait  input  1  memory busy; rises combinationally on a strobe, falls when the access completes

Behaviour:
- Reset:
  - All valid and dirty bits cleared; state goes to IDLE; beat counter set to 0.
  - readdata=0, busywait=0, mem_read=0, mem_write=0, mem_address=0, mem_writedata=0.
  - Reset mid-transfer aborts immediately; any partially filled line stays invalid.
- Hit (combinational, IDLE only): valid[index] && tag[index]==address[7:5].
- busywait = (read||write) && !(IDLE && hit). It also stays high through the cycle of the UPDATE state.
- Read hit:
  - readdata = data[index][offset] in the same cycle; busywait low.
  - Zero-cycle stall.
- Write hit:
  - Byte written at the next posedge; dirty[index] set.
  - busywait low; no memory traffic.
- read && write together: treated as no request; busywait=0 and no state change.
- States and transitions:
  - IDLE: on a miss, go to WRITEBACK if valid && dirty, otherwise go to FETCH. Beat counter cleared to 0.
  - WRITEBACK:
    - Per beat, mem_write=1, mem_address={old_tag,index,beat}, mem_writedata=data[index][beat].
    - A beat completes at a posedge where the strobe has been high at least one prior cycle and mem_busywait==0.
    - Each completed beat is followed by BEAT_GAP cycles with strobes low.
    - After beat 3: clear dirty, clear the counter, go to FETCH.
  - FETCH:
    - Same beat rules with mem_read=1 and mem_address={address[7:5],index,beat}.
    - mem_readdata is captured into data[index][beat] on completion.
    - After beat 3, go to UPDATE.
  - UPDATE (1 cycle): set tag=address[7:5] and valid=1, then return to IDLE. The request then hits and completes.
- Strobes are never both high. mem_address and mem_writedata are held stable while a strobe is high.
- Memory access latency is unbounded; the controller waits on mem_busywait indefinitely.
- The CPU must hold read, write, address and writedata stable while busywait is high. Changes during a miss are not supported.

Optional Feature:
- DCACHE_STATS_EN defined:
  - Adds outputs hit_count[15:0] and miss_count[15:0].
  - Each counts one per request resolution in IDLE (a miss counts once, not again at the post-fill hit).
  - Both saturate at 16'hFFFF and are cleared by reset.
- DCACHE_STATS_EN undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Reset, then read addr 0x05 with memory[4..7]=0x11,0x22,0x33,0x44:
  - 4 read beats to 0x04..0x07, one gap cycle between beats.
  - readdata=0x22 after UPDATE.
  - No mem_write activity.
- Read addr 0x06 immediately after: hit, busywait never rises, readdata=0x33, no memory strobes.
- Write 0xAB to 0x05 (hit), then read 0x25 (same index 1, tag 1):
  - Writeback of 0x11,0xAB,0x33,0x44 to 0x04..0x07, then fetch from 0x24..0x27.
  - Memory[5]=0xAB afterwards.
- Memory stall of 3 cycles per beat: each beat lasts 4+ cycles; no strobe overlap; address stable throughout every strobe.
- Assert reset mid-FETCH at beat 2: all outputs go to 0 asynchronously. A re-read of the same address performs a full 4-beat fetch.
- DCACHE_STATS_EN build: sequence miss, hit, hit, miss gives hit_count=2, miss_count=2.
